amp_init_sequencer: RTL
=======================

AMP_INIT_SEQUENCER -- requirements
Module: amp_init_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clk cycles per SCL quarter-bit phase (bit time = 4*CLK_DIV).
REQ-002 SHALL have parameter AMP_ADDR, default 7'h2C: 7-bit I2C address of the amplifier.
REQ-003 SHALL have parameter N_CMD, default 4: number of register writes per sequence (1..16).
REQ-004 SHALL have parameter PWRUP_CYCLES, default 1024: delay between nenable release and the first I2C START.
REQ-005 Ports: clk  in  1  single clock; one clock; reset is asynchronous and active-high.
REQ-006 Port: reset  in  1  asynchronous, active-high reset.
REQ-007 Port: start  in  1  one-cycle request to run the power-up/configuration sequence.
REQ-008 Port: mute_req  in  1  host mute request; honoured only in RUN.
REQ-009 Port: cmd_idx  out  4  index of the table entry being fetched.
REQ-010 Port: cmd_data  in  16  {reg[15:8], val[7:0]} for cmd_idx; combinational source, valid in the cycle after cmd_idx changes.
REQ-011 Port: amp_i2c_scl  out  1  SCL, push-pull, idle 1.
REQ-012 Port: amp_i2c_sdao  out  1  SDA drive value; 0 = pull low, 1 = release (open-drain).
REQ-013 Port: amp_i2c_sdai  in  1  SDA line sample.
REQ-014 Ports: amp_nenable out 1 (amp enable, active low); amp_nmute out 1 (amp mute, active low).
REQ-015 Ports: busy out 1 (sequence in progress); done out 1 (sequence completed OK, level); err out 1 (NACK seen, level).

Function
REQ-016 FSM states SHALL be IDLE, PWRUP, START, BYTE, ACK, STOP, NEXT, RUN, FAIL.
REQ-017 IDLE: start=1 -> PWRUP; amp_nenable<=0, busy<=1, done<=0, err<=0, cmd_idx<=0.
REQ-018 start SHALL be ignored in every state except IDLE, RUN and FAIL; in RUN/FAIL it restarts from PWRUP with amp_nmute<=0.
REQ-019 PWRUP SHALL count exactly PWRUP_CYCLES clk cycles, then -> START.
REQ-020 Each command SHALL be one I2C write: START, {AMP_ADDR,1'b0}, reg, val, STOP; bytes MSB first, each byte followed by one ACK bit with sdao=1.
REQ-021 START condition: SDA falls while SCL=1, held CLK_DIV cycles before SCL falls; STOP: SDA rises while SCL=1.
REQ-022 SDA SHALL change only during SCL low, one quarter-phase after the SCL falling edge.
REQ-023 ACK SHALL be sampled from amp_i2c_sdai at the midpoint of SCL high (2 quarter-phases after the rise).
REQ-024 sdai=1 at ACK -> STOP -> FAIL; a later byte of the same command SHALL NOT be sent.
REQ-025 NEXT: cmd_idx increments; cmd_idx==N_CMD-1 completed -> RUN, else -> START (re-fetch with one cycle of cmd_data settle).
REQ-026 RUN: busy=0, done=1, amp_nmute = registered ~mute_req (one-cycle latency).
REQ-027 FAIL: busy=0, err=1, amp_nmute=0, amp_nenable=1; stays until start.
REQ-028 busy SHALL be 1 in PWRUP through NEXT inclusive; done and err are never 1 simultaneously.
REQ-029 amp_nmute SHALL be 0 in every state other than RUN.
REQ-030 Bit and quarter-phase counters SHALL wrap to zero at the end of each byte/phase; no counter may overflow for N_CMD=16, CLK_DIV up to 255.

Reset
REQ-031 reset=1 SHALL immediately force: state IDLE, amp_i2c_scl=1, amp_i2c_sdao=1, amp_nenable=1, amp_nmute=0, busy=0, done=0, err=0, cmd_idx=0, all counters 0.
REQ-032 Reset asserted mid-transfer SHALL abandon the byte without a STOP; the next sequence SHALL start with a fresh START.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the I2C R/W bit constant and the 16-bit command field positions.
REQ-034 One sub-module, amp_i2c_byte_tx, SHALL serialise one byte plus ACK sample (inputs go/byte, outputs ready/nack); the top FSM handles START/STOP and sequencing.

Verification
REQ-035 Reset release, start pulse, PWRUP_CYCLES=1024 -> nenable low at cycle 1, first SDA fall at cycle 1025+; busy=1.
REQ-036 4-entry table {0x02,0x10},{0x03,0x55},{0x11,0x00},{0x7F,0xA5}, slave ACKs all -> bus decodes 0x58,reg,val ×4 with STOPs; done=1, nmute=1.
REQ-037 Slave NACKs register byte of command 2 -> STOP issued, val not sent, err=1, nenable=1, nmute=0.
REQ-038 RUN, mute_req 0->1->0 -> nmute 1->0->1, each one cycle after mute_req.
REQ-039 reset pulsed during bit 3 of the address byte -> scl=1, sdao=1, nenable=1 immediately; new start yields a clean full sequence.
REQ-040 start pulsed during BYTE -> ignored, sequence completes unchanged; start in RUN -> nmute=0, sequence reruns.

Source files
------------

// File: rtl/amp_init_sequencer_pkg.sv
// rtl/amp_init_sequencer_pkg.sv - shared types and constants for the amplifier init sequencer
package amp_init_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PWRUP,
        START,
        BYTE,
        ACK,
        STOP,
        NEXT,
        RUN,
        FAIL
    } state_t;

    localparam logic I2C_WRITE = 1'b0;

    localparam int CMD_REG_MSB = 15;
    localparam int CMD_REG_LSB = 8;
    localparam int CMD_VAL_MSB = 7;
    localparam int CMD_VAL_LSB = 0;

    function automatic logic [7:0] cmd_reg(input logic [15:0] cmd);
        return cmd[CMD_REG_MSB:CMD_REG_LSB];
    endfunction

    function automatic logic [7:0] cmd_val(input logic [15:0] cmd);
        return cmd[CMD_VAL_MSB:CMD_VAL_LSB];
    endfunction

endpackage

// File: rtl/amp_init_sequencer_byte_tx.sv
// rtl/amp_init_sequencer_byte_tx.sv - serialises one I2C byte MSB first plus the ACK bit
// Each bit is four quarter-phases: SCL low, low (SDA updated), high, high (ACK sampled at mid-high).
module amp_i2c_byte_tx #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_go,
    input  logic [7:0] i_byte,
    input  logic       i_sdai,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_nack,
    output logic       o_scl,
    output logic       o_sdao,
    output logic       o_sdao_en
);

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    logic          r_busy;
    logic          r_done;
    logic          r_nack;
    logic [8:0]    r_shift;
    logic [3:0]    r_bit;
    logic [1:0]    r_phase;
    logic [QW-1:0] r_q;
    logic          w_q_end;

    assign w_q_end = (r_q == Q_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nack  <= 1'b0;
            r_shift <= '0;
            r_bit   <= '0;
            r_phase <= '0;
            r_q     <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_go) begin
                    r_busy  <= 1'b1;
                    r_nack  <= 1'b0;
                    r_shift <= {i_byte, 1'b1};
                    r_bit   <= '0;
                    r_phase <= '0;
                    r_q     <= '0;
                end
            end else if (w_q_end) begin
                r_q     <= '0;
                r_phase <= r_phase + 2'd1;
                if (r_phase == 2'd2 && r_bit == 4'd8) begin
                    r_nack <= i_sdai;
                end
                if (r_phase == 2'd3) begin
                    if (r_bit == 4'd8) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_bit  <= '0;
                    end else begin
                        r_bit   <= r_bit + 4'd1;
                        r_shift <= {r_shift[7:0], 1'b0};
                    end
                end
            end else begin
                r_q <= r_q + QW'(1);
            end
        end
    end

    // Quarter 0 keeps the previous SDA so it only moves a quarter after SCL falls.
    assign o_ready   = ~r_busy;
    assign o_done    = r_done;
    assign o_nack    = r_nack;
    assign o_scl     = r_busy & r_phase[1];
    assign o_sdao    = r_shift[8];
    assign o_sdao_en = r_busy && (r_phase != 2'd0);

endmodule

// File: rtl/amp_init_sequencer.sv
// rtl/amp_init_sequencer.sv - powers up the amplifier and writes its register table over I2C
module amp_init_sequencer #(
    parameter int         CLK_DIV      = 16,
    parameter logic [6:0] AMP_ADDR     = 7'h2C,
    parameter int         N_CMD        = 4,
    parameter int         PWRUP_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mute_req,
    output logic [3:0]  cmd_idx,
    input  logic [15:0] cmd_data,
    output logic        amp_i2c_scl,
    output logic        amp_i2c_sdao,
    input  logic        amp_i2c_sdai,
    output logic        amp_nenable,
    output logic        amp_nmute,
    output logic        busy,
    output logic        done,
    output logic        err
);
    import amp_init_sequencer_pkg::*;

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = $clog2(PWRUP_CYCLES + 1);
    localparam logic [QW-1:0] Q_LAST   = QW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PWR_LAST = PW'(PWRUP_CYCLES - 1);
    localparam logic [3:0]    IDX_LAST = 4'(N_CMD - 1);

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_pwr, w_pwr_nxt;
    logic [QW-1:0] r_q, w_q_nxt;
    logic [1:0]    r_phase, w_phase_nxt;
    logic [1:0]    r_byte_sel, w_byte_sel_nxt;
    logic [3:0]    r_cmd_idx, w_cmd_idx_nxt;
    logic          r_fail, w_fail_nxt;
    logic          r_scl, r_sdao, r_nenable, r_nmute, r_busy, r_done, r_err;
    logic          w_scl, w_sdao, w_go;
    logic [7:0]    w_tx_byte;
    logic          w_q_end;
    logic          w_tx_ready, w_tx_done, w_tx_nack, w_tx_scl, w_tx_sdao, w_tx_sdao_en;

    amp_i2c_byte_tx #(.CLK_DIV(CLK_DIV)) u_byte_tx (
        .clk       (clk),
        .reset     (reset),
        .i_go      (w_go & w_tx_ready),
        .i_byte    (w_tx_byte),
        .i_sdai    (amp_i2c_sdai),
        .o_ready   (w_tx_ready),
        .o_done    (w_tx_done),
        .o_nack    (w_tx_nack),
        .o_scl     (w_tx_scl),
        .o_sdao    (w_tx_sdao),
        .o_sdao_en (w_tx_sdao_en)
    );

    assign w_q_end = (r_q == Q_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pwr      <= '0;
            r_q        <= '0;
            r_phase    <= '0;
            r_byte_sel <= '0;
            r_cmd_idx  <= '0;
            r_fail     <= 1'b0;
            r_scl      <= 1'b1;
            r_sdao     <= 1'b1;
            r_nenable  <= 1'b1;
            r_nmute    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pwr      <= w_pwr_nxt;
            r_q        <= w_q_nxt;
            r_phase    <= w_phase_nxt;
            r_byte_sel <= w_byte_sel_nxt;
            r_cmd_idx  <= w_cmd_idx_nxt;
            r_fail     <= w_fail_nxt;
            r_scl      <= w_scl;
            r_sdao     <= w_sdao;
            r_nenable  <= (w_state_nxt == IDLE) || (w_state_nxt == FAIL);
            r_nmute    <= (w_state_nxt == RUN) && !mute_req;
            r_busy     <= !((w_state_nxt == IDLE) || (w_state_nxt == RUN) || (w_state_nxt == FAIL));
            r_done     <= (w_state_nxt == RUN);
            r_err      <= (w_state_nxt == FAIL);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pwr_nxt      = r_pwr;
        w_q_nxt        = r_q;
        w_phase_nxt    = r_phase;
        w_byte_sel_nxt = r_byte_sel;
        w_cmd_idx_nxt  = r_cmd_idx;
        w_fail_nxt     = r_fail;
        w_go           = 1'b0;
        w_tx_byte      = 8'h00;
        w_scl          = 1'b1;
        w_sdao         = r_sdao;

        case (r_state)
            IDLE, RUN, FAIL: begin
                w_sdao = 1'b1;
                if (start) begin
                    w_state_nxt   = PWRUP;
                    w_pwr_nxt     = '0;
                    w_cmd_idx_nxt = '0;
                    w_fail_nxt    = 1'b0;
                end
            end
            PWRUP: begin
                w_sdao = 1'b1;
                if (r_pwr == PWR_LAST) begin
                    w_state_nxt = START;
                    w_pwr_nxt   = '0;
                    w_q_nxt     = '0;
                    w_phase_nxt = '0;
                end else begin
                    w_pwr_nxt = r_pwr + PW'(1);
                end
            end
            START: begin
                w_sdao = (r_phase == 2'd0);
                if (w_q_end) begin
                    w_q_nxt = '0;
                    if (r_phase == 2'd1) begin
                        w_phase_nxt    = '0;
                        w_byte_sel_nxt = '0;
                        w_go           = 1'b1;
                        w_tx_byte      = {AMP_ADDR, I2C_WRITE};
                        w_state_nxt    = BYTE;
                    end else begin
                        w_phase_nxt = r_phase + 2'd1;
                    end
                end else begin
                    w_q_nxt = r_q + QW'(1);
                end
            end
            BYTE: begin
                w_scl = w_tx_scl;
                if (w_tx_sdao_en) begin
                    w_sdao = w_tx_sdao;
                end
                if (w_tx_done) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_scl       = 1'b0;
                w_q_nxt     = '0;
                w_phase_nxt = '0;
                if (w_tx_nack) begin
                    w_fail_nxt  = 1'b1;
                    w_state_nxt = STOP;
                end else if (r_byte_sel == 2'd2) begin
                    w_state_nxt = STOP;
                end else begin
                    w_byte_sel_nxt = r_byte_sel + 2'd1;
                    w_go           = 1'b1;
                    w_tx_byte      = (r_byte_sel == 2'd0) ? cmd_reg(cmd_data) : cmd_val(cmd_data);
                    w_state_nxt    = BYTE;
                end
            end
            STOP: begin
                w_scl = r_phase[1];
                if (r_phase != 2'd0) begin
                    w_sdao = (r_phase == 2'd3);
                end
                if (w_q_end) begin
                    w_q_nxt     = '0;
                    w_phase_nxt = r_phase + 2'd1;
                    if (r_phase == 2'd3) begin
                        w_state_nxt = r_fail ? FAIL : NEXT;
                    end
                end else begin
                    w_q_nxt = r_q + QW'(1);
                end
            end
            NEXT: begin
                w_sdao      = 1'b1;
                w_q_nxt     = '0;
                w_phase_nxt = '0;
                // Holding the last index avoids wrapping cmd_idx when N_CMD is 16.
                if (r_cmd_idx == IDX_LAST) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cmd_idx_nxt = r_cmd_idx + 4'd1;
                    w_state_nxt   = START;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_idx      = r_cmd_idx;
    assign amp_i2c_scl  = r_scl;
    assign amp_i2c_sdao = r_sdao;
    assign amp_nenable  = r_nenable;
    assign amp_nmute    = r_nmute;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule
